// File: rtl/blit_outer_seq.sv
// Outer-loop control sequencer for the TOM blitter: launches one inner pass per
// outer iteration, steps the A1/A1F/A2 update strobes and decrements the outer counter.
module blit_outer_seq #(
   parameter int unsigned UPD_WAIT = 1
) (
   input  logic clk,
   input  logic resetl,
   input  logic go,
   input  logic stop,
   input  logic upda1,
   input  logic upda1f,
   input  logic upda2,
   input  logic outer0,
   input  logic inner_done,
   output logic inner_start,
   output logic a1_add,
   output logic a1f_add,
   output logic a2_add,
   output logic ocntena,
   output logic busy,
   output logic blit_done
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_START      = 4'd1,
      S_WAIT_INNER = 4'd2,
      S_UPD_A1     = 4'd3,
      S_UPD_A1F    = 4'd4,
      S_UPD_A2     = 4'd5,
      S_DEC        = 4'd6,
      S_CHECK      = 4'd7,
      S_DONE       = 4'd8
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(UPD_WAIT - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_wcnt;
   logic [3:0] w_wcnt_dec;
   logic [3:0] w_wcnt_nxt;
   logic       w_enter_upd;
   logic       w_accept;
   logic       r_f_a1;
   logic       r_f_a1f;
   logic       r_f_a2;
   logic       r_inner_start;
   logic       r_a1_add;
   logic       r_a1f_add;
   logic       r_a2_add;
   logic       r_ocntena;
   logic       r_busy;
   logic       r_blit_done;

   // stage: 0 after inner pass, 1 after A1, 2 after A1F, 3 after A2; disabled updates are skipped
   function automatic state_t next_upd(input logic [1:0] stage, input logic f_a1,
                                       input logic f_a1f, input logic f_a2);
      state_t s;
      if (stage == 2'd0 && f_a1) begin
         s = S_UPD_A1;
      end else if (stage <= 2'd1 && f_a1f) begin
         s = S_UPD_A1F;
      end else if (stage <= 2'd2 && f_a2) begin
         s = S_UPD_A2;
      end else begin
         s = S_DEC;
      end
      return s;
   endfunction

   // Next-state decode; stop overrides every transition
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_dec  = r_wcnt;
      case (r_state)
         S_IDLE: begin
            if (go) w_state_nxt = S_START;
            else    w_state_nxt = S_IDLE;
         end
         S_START:      w_state_nxt = S_WAIT_INNER;
         S_WAIT_INNER: begin
            if (inner_done) w_state_nxt = next_upd(2'd0, r_f_a1, r_f_a1f, r_f_a2);
            else            w_state_nxt = S_WAIT_INNER;
         end
         S_UPD_A1: begin
            if (r_wcnt == 4'd0) w_state_nxt = next_upd(2'd1, r_f_a1, r_f_a1f, r_f_a2);
            else                w_wcnt_dec  = r_wcnt - 4'd1;
         end
         S_UPD_A1F: begin
            if (r_wcnt == 4'd0) w_state_nxt = next_upd(2'd2, r_f_a1, r_f_a1f, r_f_a2);
            else                w_wcnt_dec  = r_wcnt - 4'd1;
         end
         S_UPD_A2: begin
            if (r_wcnt == 4'd0) w_state_nxt = S_DEC;
            else                w_wcnt_dec  = r_wcnt - 4'd1;
         end
         S_DEC:   w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (outer0) w_state_nxt = S_DONE;
            else        w_state_nxt = S_START;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (stop) begin
         w_state_nxt = S_IDLE;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   assign w_enter_upd = (w_state_nxt != r_state) &&
                        (w_state_nxt == S_UPD_A1 || w_state_nxt == S_UPD_A1F ||
                         w_state_nxt == S_UPD_A2);
   assign w_accept    = (r_state == S_IDLE) && go && !stop;

   // Wait counter reloads on entry to each update state so every strobe lasts UPD_WAIT cycles
   always_comb begin
      if (stop) begin
         w_wcnt_nxt = 4'd0;
      end else if (w_enter_upd) begin
         w_wcnt_nxt = WAIT_LOAD;
      end else begin
         w_wcnt_nxt = w_wcnt_dec;
      end
   end

   // State, wait counter and command flags latched at the accepted go
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         r_state <= S_IDLE;
         r_wcnt  <= 4'd0;
         r_f_a1  <= 1'b0;
         r_f_a1f <= 1'b0;
         r_f_a2  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         if (w_accept) begin
            r_f_a1  <= upda1;
            r_f_a1f <= upda1f;
            r_f_a2  <= upda2;
         end else begin
            r_f_a1  <= r_f_a1;
            r_f_a1f <= r_f_a1f;
            r_f_a2  <= r_f_a2;
         end
      end
   end

   // Outputs are registered decodes of the next state, so they track the state register exactly
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         r_inner_start <= 1'b0;
         r_a1_add      <= 1'b0;
         r_a1f_add     <= 1'b0;
         r_a2_add      <= 1'b0;
         r_ocntena     <= 1'b0;
         r_busy        <= 1'b0;
         r_blit_done   <= 1'b0;
      end else begin
         r_inner_start <= (w_state_nxt == S_START);
         r_a1_add      <= (w_state_nxt == S_UPD_A1);
         r_a1f_add     <= (w_state_nxt == S_UPD_A1F);
         r_a2_add      <= (w_state_nxt == S_UPD_A2);
         r_ocntena     <= (w_state_nxt == S_DEC);
         r_busy        <= (w_state_nxt != S_IDLE);
         r_blit_done   <= (w_state_nxt == S_DONE);
      end
   end

   assign inner_start = r_inner_start;
   assign a1_add      = r_a1_add;
   assign a1f_add     = r_a1f_add;
   assign a2_add      = r_a2_add;
   assign ocntena     = r_ocntena;
   assign busy        = r_busy;
   assign blit_done   = r_blit_done;

endmodule

// File: tb/tb_blit_outer_seq.sv
// Scoreboard bench for blit_outer_seq: stimulus queues expected output events,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_blit_outer_seq;
   localparam int W = 2;
   localparam logic [5:0] E_IS  = 6'b100000;
   localparam logic [5:0] E_A1  = 6'b010000;
   localparam logic [5:0] E_A1F = 6'b001000;
   localparam logic [5:0] E_A2  = 6'b000100;
   localparam logic [5:0] E_OC  = 6'b000010;
   localparam logic [5:0] E_BD  = 6'b000001;

   logic clk = 1'b0;
   logic resetl = 1'b0;
   logic go = 1'b0, stop = 1'b0;
   logic upda1 = 1'b0, upda1f = 1'b0, upda2 = 1'b0;
   logic inner_done = 1'b0;
   logic outer0;
   logic inner_start, a1_add, a1f_add, a2_add, ocntena, busy, blit_done;

   logic [15:0] r_cnt = 16'd0;
   logic        ld_en = 1'b0;
   logic [15:0] ld_val = 16'd0;
   int          inner_len = 3;
   int          k = 0;
   int          n_tests = 0, n_fail = 0;
   int          cyc = 0, oc_cyc = 0;
   logic        prev_bd = 1'b0;
   logic [5:0]  exp_q[$];

   blit_outer_seq #(.UPD_WAIT(W)) dut (
      .clk(clk), .resetl(resetl), .go(go), .stop(stop),
      .upda1(upda1), .upda1f(upda1f), .upda2(upda2),
      .outer0(outer0), .inner_done(inner_done),
      .inner_start(inner_start), .a1_add(a1_add), .a1f_add(a1f_add), .a2_add(a2_add),
      .ocntena(ocntena), .busy(busy), .blit_done(blit_done)
   );

   always #5 clk = ~clk;

   // Outer down-counter model; its load belongs to the register path, here the bench
   always @(posedge clk) begin
      if (ld_en) r_cnt <= ld_val;
      else if (ocntena) r_cnt <= r_cnt - 16'd1;
   end
   assign outer0 = (r_cnt == 16'd0);

   // Inner-loop model: inner_done pulses inner_len cycles after inner_start
   initial forever begin
      @(negedge clk);
      inner_done = 1'b0;
      if (inner_start) k = inner_len;
      else if (k > 0) begin
         k = k - 1;
         if (k == 0) inner_done = 1'b1;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] ev_now();
      return {inner_start, a1_add, a1f_add, a2_add, ocntena, blit_done};
   endfunction

   // Monitor
   initial forever begin
      logic [5:0] ev;
      @(negedge clk);
      cyc++;
      ev = ev_now();
      if (prev_bd) check("busy_after_done", 32'(busy), 32'd0);
      prev_bd = blit_done;
      if (ocntena) oc_cyc = cyc;
      if (blit_done) check("done_latency", 32'(cyc - oc_cyc), 32'd2);
      if (ev != 6'd0) begin
         if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 32'd0);
         else check("event", 32'(ev), 32'(exp_q.pop_front()));
      end
   end

   task automatic push_pass(input logic f1, input logic f1f, input logic f2);
      exp_q.push_back(E_IS);
      if (f1)  for (int i = 0; i < W; i++) exp_q.push_back(E_A1);
      if (f1f) for (int i = 0; i < W; i++) exp_q.push_back(E_A1F);
      if (f2)  for (int i = 0; i < W; i++) exp_q.push_back(E_A2);
      exp_q.push_back(E_OC);
   endtask

   // Loads the counter, issues go with flags, returns at the negedge of the START cycle
   task automatic start_blit(input logic f1, input logic f1f, input logic f2, input logic [15:0] n);
      @(negedge clk);
      ld_en = 1'b1; ld_val = n;
      @(negedge clk);
      ld_en = 1'b0;
      go = 1'b1; upda1 = f1; upda1f = f1f; upda2 = f2;
      @(negedge clk);
      go = 1'b0; upda1 = ~f1; upda1f = ~f1f; upda2 = ~f2;
      check("busy_after_go", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(n < budget), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int  n;
      logic ok;
      // reset
      #23;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_outputs", 32'(ev_now()), 32'd0);
      resetl = 1'b1;

      // T1: count 1, no updates
      inner_len = 3;
      push_pass(1'b0, 1'b0, 1'b0); exp_q.push_back(E_BD);
      start_blit(1'b0, 1'b0, 1'b0, 16'd1);
      wait_idle(100);

      // T2: count 3, A1 and A2 updates
      for (int p = 0; p < 3; p++) push_pass(1'b1, 1'b0, 1'b1);
      exp_q.push_back(E_BD);
      start_blit(1'b1, 1'b0, 1'b1, 16'd3);
      wait_idle(200);

      // T3: count 0 wraps; run 5 passes then abort
      inner_len = 1;
      for (int p = 0; p < 5; p++) push_pass(1'b0, 1'b0, 1'b0);
      start_blit(1'b0, 1'b0, 1'b0, 16'd0);
      n = 0; ok = 1'b1;
      while (r_cnt != 16'hFFFB && n < 500) begin
         @(negedge clk);
         if (!busy) ok = 1'b0;
         n++;
      end
      check("wrap_timeout", 32'(n < 500), 32'd1);
      check("wrap_busy_continuous", 32'(ok), 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("wrap_stop_busy", 32'(busy), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      // T4: stop in first A1F cycle of pass 2 of 4, then a fresh blit
      inner_len = 3;
      push_pass(1'b1, 1'b1, 1'b0);
      exp_q.push_back(E_IS); exp_q.push_back(E_A1); exp_q.push_back(E_A1); exp_q.push_back(E_A1F);
      start_blit(1'b1, 1'b1, 1'b0, 16'd4);
      n = 0;
      while (!(a1f_add && r_cnt == 16'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("stop_point_timeout", 32'(n < 200), 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_outputs", 32'(ev_now()), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      push_pass(1'b0, 1'b0, 1'b1); exp_q.push_back(E_BD);
      start_blit(1'b0, 1'b0, 1'b1, 16'd1);
      wait_idle(100);

      // T5: go and flag changes while busy are ignored
      push_pass(1'b0, 1'b1, 1'b0); push_pass(1'b0, 1'b1, 1'b0); exp_q.push_back(E_BD);
      start_blit(1'b0, 1'b1, 1'b0, 16'd2);
      repeat (2) @(negedge clk);
      go = 1'b1; upda1 = 1'b1; upda1f = 1'b0; upda2 = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (4) @(negedge clk);
      go = 1'b1; upda1 = 1'b1; upda2 = 1'b0;
      @(negedge clk);
      go = 1'b0; upda1 = 1'b0; upda1f = 1'b0; upda2 = 1'b0;
      wait_idle(200);

      // T6: asynchronous reset during WAIT_INNER; late inner_done must do nothing
      inner_len = 6;
      exp_q.push_back(E_IS);
      start_blit(1'b1, 1'b0, 1'b0, 16'd2);
      @(negedge clk);
      #2 resetl = 1'b0;
      #1;
      check("async_reset_busy", 32'(busy), 32'd0);
      check("async_reset_outputs", 32'(ev_now()), 32'd0);
      @(negedge clk);
      resetl = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (busy) ok = 1'b0;
      end
      check("late_done_ignored", 32'(ok), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
